// File: rtl/anc_lms_ctrl.sv
// Per-sample LMS step controller in front of the adaptive FIR: takes one sample set,
// forms the Q1.15 weight step mu*e, starts the FIR, and captures its result.
module anc_lms_ctrl #(
    parameter int TIMEOUT_CYC = 300,
    parameter int CW          = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] x_sample,
    input  logic [15:0] e_sample,
    input  logic [15:0] a_sample,
    input  logic [15:0] mu,
    input  logic        adapt_en,
    output logic        fir_go,
    output logic [15:0] x_in,
    output logic [15:0] a_in,
    output logic [15:0] weight_adjust,
    input  logic        fir_done,
    input  logic [15:0] fir_out_sample,
    output logic [15:0] y_out,
    output logic        y_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout,
    input  logic        clr_flags,
    output logic [1:0]  state_dbg
);
    // Sample handshake: a set is taken on any clock where sample_valid && sample_ready;
    // sample_valid while sample_ready is low is dropped and flagged as overrun.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        GO   = 2'd2,
        WAIT = 2'd3
    } state_t;

    // Abort fires on the WAIT cycle in which the watchdog count reaches TIMEOUT_CYC.
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t             r_state;
    logic signed [15:0] r_e;
    logic signed [15:0] r_mu;
    logic               r_adapt;
    logic [CW-1:0]      r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_fir_go;
    logic               r_y_valid;
    logic               r_overrun;
    logic               r_timeout;
    logic [15:0]        r_x_in;
    logic [15:0]        r_a_in;
    logic [15:0]        r_wadj;
    logic [15:0]        r_y_out;

    logic               w_accept;
    logic               w_drop;
    logic               w_timeout_evt;
    logic signed [31:0] w_prod;
    logic signed [16:0] w_prod_q;
    logic [15:0]        w_wadj_sat;

    assign w_accept      = sample_valid && r_ready;
    assign w_drop        = sample_valid && !r_ready;
    assign w_timeout_evt = (r_state == WAIT) && !fir_done && (r_cnt == LP_CNT_LAST);

    assign w_prod   = 32'(r_mu) * 32'(r_e);
    assign w_prod_q = 17'(w_prod >>> 15);

    // The 17-bit Q1.15 result fits in 16 bits only when its top two bits agree.
    always_comb begin
        w_wadj_sat = w_prod_q[15:0];
        if (w_prod_q[16] != w_prod_q[15]) begin
            w_wadj_sat = w_prod_q[16] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_e       <= '0;
            r_mu      <= '0;
            r_adapt   <= 1'b0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_fir_go  <= 1'b0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_x_in    <= '0;
            r_a_in    <= '0;
            r_wadj    <= '0;
            r_y_out   <= '0;
        end else begin
            r_fir_go  <= 1'b0;
            r_y_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x_in  <= x_sample;
                        r_a_in  <= a_sample;
                        r_e     <= e_sample;
                        r_mu    <= mu;
                        r_adapt <= adapt_en;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_wadj   <= r_adapt ? w_wadj_sat : 16'h0000;
                    r_fir_go <= 1'b1;
                    r_state  <= GO;
                end
                GO: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (fir_done) begin
                        r_y_out   <= fir_out_sample;
                        r_y_valid <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new flag event outranks a clear in the same cycle.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_flags) begin
                r_overrun <= 1'b0;
            end
            if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end else if (clr_flags) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign sample_ready  = r_ready;
    assign busy          = r_busy;
    assign fir_go        = r_fir_go;
    assign x_in          = r_x_in;
    assign a_in          = r_a_in;
    assign weight_adjust = r_wadj;
    assign y_out         = r_y_out;
    assign y_valid       = r_y_valid;
    assign overrun       = r_overrun;
    assign timeout       = r_timeout;
    assign state_dbg     = r_state;
endmodule

// File: tb/tb_anc_lms_ctrl.sv
// Directed bench for anc_lms_ctrl: a transaction-timestamp model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
`timescale 1ns/1ps
module tb_anc_lms_ctrl;
    localparam int TIMEOUT_CYC = 300;
    localparam int CW          = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] x_sample = '0;
    logic [15:0] e_sample = '0;
    logic [15:0] a_sample = '0;
    logic [15:0] mu = '0;
    logic        adapt_en = 1'b0;
    logic        fir_go;
    logic [15:0] x_in;
    logic [15:0] a_in;
    logic [15:0] weight_adjust;
    logic        fir_done = 1'b0;
    logic [15:0] fir_out_sample = '0;
    logic [15:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        overrun;
    logic        timeout;
    logic        clr_flags = 1'b0;
    logic [1:0]  state_dbg;

    anc_lms_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .x_sample(x_sample), .e_sample(e_sample), .a_sample(a_sample),
        .mu(mu), .adapt_en(adapt_en),
        .fir_go(fir_go), .x_in(x_in), .a_in(a_in), .weight_adjust(weight_adjust),
        .fir_done(fir_done), .fir_out_sample(fir_out_sample),
        .y_out(y_out), .y_valid(y_valid), .busy(busy),
        .overrun(overrun), .timeout(timeout), .clr_flags(clr_flags),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_go    = 0;
    int n_yv    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Q1.15 step from plain integer arithmetic: floor(mu*e / 2^15), clamped to 16 bits.
    function automatic logic [15:0] lms_step(input logic [15:0] m, input logic [15:0] e);
        int p;
        int q;
        p = $signed(m) * $signed(e);
        q = p >>> 15;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    // Model: a transaction is timed from its accept edge; fir_go is one edge later,
    // done counts from the third edge on, and abort happens TIMEOUT_CYC+2 edges after accept.
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_acc = 0;
    logic [15:0] m_x = '0, m_a = '0, m_wa = '0, m_y = '0;
    bit          m_yv = 1'b0, m_ov = 1'b0, m_to = 1'b0;

    always @(posedge clk) begin
        bit ov_evt;
        bit to_evt;
        cyc++;
        m_yv = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_x = '0; m_a = '0; m_wa = '0; m_y = '0;
            m_ov = 1'b0; m_to = 1'b0;
        end else begin
            ov_evt = sample_valid && m_active;
            to_evt = 1'b0;
            if (m_active) begin
                if (fir_done && (cyc - m_acc) >= 3) begin
                    m_y = fir_out_sample;
                    m_yv = 1'b1;
                    m_active = 1'b0;
                end else if ((cyc - m_acc) == TIMEOUT_CYC + 2) begin
                    to_evt = 1'b1;
                    m_active = 1'b0;
                end
            end else if (sample_valid) begin
                m_active = 1'b1;
                m_acc = cyc;
                m_x = x_sample;
                m_a = a_sample;
                m_wa = adapt_en ? lms_step(mu, e_sample) : 16'h0000;
            end
            if (ov_evt) m_ov = 1'b1;
            else if (clr_flags) m_ov = 1'b0;
            if (to_evt) m_to = 1'b1;
            else if (clr_flags) m_to = 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("sample_ready", sample_ready, !m_active);
        chk("busy", busy, m_active);
        chk("fir_go", fir_go, m_active && (cyc - m_acc) == 1);
        chk("y_valid", y_valid, m_yv);
        chk("y_out", y_out, m_y);
        chk("overrun", overrun, m_ov);
        chk("timeout", timeout, m_to);
        if (!(m_active && (cyc - m_acc) == 0)) begin
            chk("x_in", x_in, m_x);
            chk("a_in", a_in, m_a);
            chk("weight_adjust", weight_adjust, m_wa);
        end
        if (fir_go) n_go++;
        if (y_valid) n_yv++;
    end

    task automatic send(input logic [15:0] x, input logic [15:0] e, input logic [15:0] a,
                        input logic [15:0] m, input logic ad);
        @(negedge clk);
        x_sample = x; e_sample = e; a_sample = a; mu = m; adapt_en = ad;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_go(output int k);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            k++;
            if (fir_go) break;
        end
    endtask

    task automatic finish_txn(input int n, input logic [15:0] val);
        repeat (n) @(negedge clk);
        fir_done = 1'b1;
        fir_out_sample = val;
        @(negedge clk);
        fir_done = 1'b0;
        chk("txn_y_valid", y_valid, 1'b1);
        chk("txn_y_out", y_out, val);
        @(negedge clk);
        chk("txn_y_valid_drop", y_valid, 1'b0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    initial begin
        int k;
        int go0;
        int yv0;
        repeat (3) @(negedge clk);
        chk("rst_ready", sample_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fir_go", fir_go, 1'b0);
        chk("rst_wadj", weight_adjust, 16'h0000);
        rst_n = 1'b1;

        // Basic transaction.
        send(16'h1234, 16'h2000, 16'h0100, 16'h4000, 1'b1);
        wait_go(k);
        chk("basic_go_latency", k, 1);
        chk("basic_wadj", weight_adjust, 16'h1000);
        chk("basic_x_in", x_in, 16'h1234);
        chk("basic_a_in", a_in, 16'h0100);
        chk("basic_go_count", n_go, 1);
        finish_txn(270, 16'h0ABC);
        chk("basic_go_count_end", n_go, 1);

        // Saturation and freeze.
        send(16'h0001, 16'h8000, 16'h0000, 16'h8000, 1'b1);
        wait_go(k);
        chk("sat_pos_wadj", weight_adjust, 16'h7FFF);
        finish_txn(5, 16'h1111);
        send(16'h0002, 16'h7FFF, 16'h0000, 16'h8000, 1'b1);
        wait_go(k);
        chk("sat_neg_wadj", weight_adjust, 16'h8001);
        finish_txn(5, 16'h2222);
        send(16'h0003, 16'h2000, 16'h0000, 16'h4000, 1'b0);
        wait_go(k);
        chk("freeze_wadj", weight_adjust, 16'h0000);
        finish_txn(5, 16'h3333);

        // Overrun while waiting.
        chk("ovr_before", overrun, 1'b0);
        go0 = n_go;
        send(16'h0AAA, 16'h1000, 16'h0010, 16'h1000, 1'b1);
        wait_go(k);
        chk("ovr_wadj", weight_adjust, 16'h0200);
        repeat (8) @(negedge clk);
        x_sample = 16'h7777;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_x_in_held", x_in, 16'h0AAA);
        finish_txn(20, 16'h4444);
        chk("ovr_go_count", n_go, go0 + 1);
        pulse_clr();
        chk("ovr_cleared", overrun, 1'b0);

        // Overrun on the fir_done cycle, then clear colliding with a new drop.
        send(16'h0101, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        wait_go(k);
        repeat (4) @(negedge clk);
        fir_done = 1'b1; fir_out_sample = 16'h5A5A; sample_valid = 1'b1;
        @(negedge clk);
        fir_done = 1'b0; sample_valid = 1'b0;
        chk("done_cyc_y_valid", y_valid, 1'b1);
        chk("done_cyc_overrun", overrun, 1'b1);
        chk("done_cyc_ready", sample_ready, 1'b1);
        send(16'h0202, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        wait_go(k);
        @(negedge clk);
        clr_flags = 1'b1; sample_valid = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0; sample_valid = 1'b0;
        chk("set_wins_overrun", overrun, 1'b1);
        finish_txn(3, 16'h0F00);
        pulse_clr();
        chk("ovr_cleared2", overrun, 1'b0);

        // Watchdog abort.
        yv0 = n_yv;
        send(16'h0303, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        wait_go(k);
        repeat (TIMEOUT_CYC) @(negedge clk);
        chk("to_not_yet", timeout, 1'b0);
        chk("to_busy", busy, 1'b1);
        @(negedge clk);
        chk("to_set", timeout, 1'b1);
        chk("to_ready", sample_ready, 1'b1);
        chk("to_no_y_valid", n_yv, yv0);
        chk("to_y_out_held", y_out, 16'h0F00);
        send(16'h0404, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        wait_go(k);
        chk("to_next_go", k, 1);
        finish_txn(10, 16'h6666);
        chk("to_sticky", timeout, 1'b1);
        pulse_clr();
        chk("to_cleared", timeout, 1'b0);

        // Done on the exact abort cycle wins; one cycle later it is ignored.
        send(16'h0505, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        wait_go(k);
        finish_txn(TIMEOUT_CYC, 16'h7123);
        chk("edge_no_timeout", timeout, 1'b0);
        send(16'h0606, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        wait_go(k);
        repeat (TIMEOUT_CYC + 1) @(negedge clk);
        fir_done = 1'b1; fir_out_sample = 16'h1357;
        @(negedge clk);
        fir_done = 1'b0;
        chk("late_no_y_valid", y_valid, 1'b0);
        chk("late_timeout", timeout, 1'b1);
        chk("late_y_out_held", y_out, 16'h7123);
        @(negedge clk);
        fir_done = 1'b1; fir_out_sample = 16'h2468;
        @(negedge clk);
        fir_done = 1'b0;
        chk("idle_done_ignored", y_valid, 1'b0);
        chk("idle_done_y_out", y_out, 16'h7123);
        pulse_clr();

        // Async reset in the middle of WAIT.
        send(16'h0707, 16'h2000, 16'h0033, 16'h4000, 1'b1);
        wait_go(k);
        repeat (5) @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("mid_overrun", overrun, 1'b1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", sample_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_fir_go", fir_go, 1'b0);
        chk("arst_x_in", x_in, 16'h0000);
        chk("arst_a_in", a_in, 16'h0000);
        chk("arst_wadj", weight_adjust, 16'h0000);
        chk("arst_y_out", y_out, 16'h0000);
        chk("arst_y_valid", y_valid, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        chk("arst_timeout", timeout, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(16'h0808, 16'h2000, 16'h0044, 16'h4000, 1'b1);
        wait_go(k);
        chk("post_rst_go_latency", k, 1);
        chk("post_rst_wadj", weight_adjust, 16'h1000);
        finish_txn(5, 16'h0F0F);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: bench did not complete, got running, expected done");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
